// File: rtl/rs232_pkg.sv
// Shared UART register map, letter-code constants, TX FSM encoding and code->ASCII helper
// for the RS232 RX/TX Avalon masters.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         RX_OK_BIT   = 7;
  localparam int         TX_OK_BIT   = 6;

  localparam logic [5:0] CODE_SPACE  = 6'd52;
  localparam logic [5:0] CODE_LF     = 6'd63;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QUERY = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  // Codes 53..62 are unassigned and print as '?'.
  function automatic logic [7:0] code_to_ascii(input logic [5:0] code);
    if (code < 6'd26)
      return 8'h61 + {2'b00, code};
    else if (code < 6'd52)
      return 8'h41 + ({2'b00, code} - 8'd26);
    else if (code == CODE_SPACE)
      return 8'h20;
    else if (code == CODE_LF)
      return 8'h0A;
    else
      return 8'h3F;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO, registered pointers, head visible combinationally; zero-latency read.
// Push while full and pop while empty are ignored; caller gates push on !full.
module tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs232_tx_sender.sv
// Avalon-MM master: buffers letter codes, polls UART status for TX ready, writes ASCII byte.
// Push->read 1 cycle, ->write 2, ->pop 3; strobes hold under waitrequest, pushes refused when full.
module rs232_tx_sender #(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [4:0] TX_BASE     = rs232_pkg::TX_BASE,
  parameter logic [4:0] STATUS_BASE = rs232_pkg::STATUS_BASE,
  parameter int         TX_OK_BIT   = rs232_pkg::TX_OK_BIT
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic        i_letter_valid,
  input  logic [7:0]  i_letter,
  output logic        o_letter_ready,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic          fifo_push;
  logic          fifo_pop;
  logic [5:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          more_after_pop;
  logic          unused_bits;

  assign unused_bits    = ^{avm_readdata, i_letter[7:6]};
  assign o_letter_ready = !fifo_full;
  assign fifo_push      = i_letter_valid && !fifo_full;
  assign fifo_pop       = (state == rs232_pkg::S_WRITE) && !avm_waitrequest;
  // A push landing on the pop edge keeps the queue non-empty even if the head was last.
  assign more_after_pop = (fifo_count > CW'(1)) || fifo_push;
  assign o_busy         = (state != rs232_pkg::S_IDLE) || !fifo_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (6)
  ) u_fifo (
    .clk       (avm_clk),
    .rst_n     (avm_rst_n),
    .push      (fifo_push),
    .push_data (i_letter[5:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      o_overflow <= 1'b0;
    end else if (i_letter_valid && fifo_full) begin
      o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state         <= rs232_pkg::S_IDLE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      case (state)
        rs232_pkg::S_IDLE: begin
          if (!fifo_empty) begin
            avm_read    <= 1'b1;
            avm_address <= STATUS_BASE;
            state       <= rs232_pkg::S_QUERY;
          end
        end
        rs232_pkg::S_QUERY: begin
          // Not ready: read stays high, which re-issues the status poll next cycle.
          if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= TX_BASE;
            avm_writedata <= {24'b0, rs232_pkg::code_to_ascii(fifo_head)};
            state         <= rs232_pkg::S_WRITE;
          end
        end
        rs232_pkg::S_WRITE: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            if (more_after_pop) begin
              avm_read    <= 1'b1;
              avm_address <= STATUS_BASE;
              state       <= rs232_pkg::S_QUERY;
            end else begin
              state <= rs232_pkg::S_IDLE;
            end
          end
        end
        default: state <= rs232_pkg::S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_sender.sv
// Bench for rs232_tx_sender: Avalon slave BFM with programmable stalls/TX_OK and a byte scoreboard.
`timescale 1ns/1ps
module tb_rs232_tx_sender;

  logic        avm_clk = 1'b0;
  logic        avm_rst_n = 1'b0;
  logic        i_letter_valid = 1'b0;
  logic [7:0]  i_letter = '0;
  logic        o_letter_ready;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        o_busy;
  logic        o_overflow;

  always #5 avm_clk = ~avm_clk;

  rs232_tx_sender dut (
    .avm_clk         (avm_clk),
    .avm_rst_n       (avm_rst_n),
    .i_letter_valid  (i_letter_valid),
    .i_letter        (i_letter),
    .o_letter_ready  (o_letter_ready),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of bytes still owed to the UART, plus occupancy and sticky overflow.
  byte unsigned exp_q[$];
  byte unsigned wr_log[$];
  int           polls_q[$];
  int           model_count = 0;
  bit           ovf_exp = 0;
  int           n_reads = 0, n_writes = 0, n_wr_stalls = 0, n_pushed = 0;
  int           reads_since_write = 0;

  bit           tx_hold = 0, rnd_wait = 0;
  int           poll_fail_left = 0, wr_stall = 0, wr_wait_cnt = 0;
  bit           prev_rd_stall = 0, prev_wr_stall = 0;
  logic [4:0]   prev_addr = '0;
  logic [31:0]  prev_wdata = '0;

  function automatic byte unsigned ref_ascii(input int code);
    string letters;
    int c;
    letters = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ";
    c = code % 64;
    if (c < 52)  return letters[c];
    if (c == 52) return 8'h20;
    if (c == 63) return 8'h0A;
    return 8'h3F;
  endfunction

  task automatic cycle(input bit v, input logic [7:0] l);
    bit rd_acc, wr_acc, push_acc;
    @(negedge avm_clk);
    i_letter_valid = v;
    i_letter       = l;
    if (prev_wr_stall) begin
      chk("wr_hold_strobe", 32'(avm_write), 32'd1);
      chk("wr_hold_addr", 32'(avm_address), 32'(prev_addr));
      chk("wr_hold_data", avm_writedata, prev_wdata);
    end
    if (prev_rd_stall) begin
      chk("rd_hold_strobe", 32'(avm_read), 32'd1);
      chk("rd_hold_addr", 32'(avm_address), 32'(prev_addr));
    end
    if (avm_read || avm_write) chk("rw_exclusive", 32'(avm_read & avm_write), 32'd0);
    chk("ready", 32'(o_letter_ready), 32'(model_count < 16));
    chk("overflow", 32'(o_overflow), 32'(ovf_exp));

    avm_waitrequest = 1'b0;
    avm_readdata    = $urandom;
    if (avm_write) begin
      if (wr_wait_cnt < wr_stall) begin
        avm_waitrequest = 1'b1;
        wr_wait_cnt++;
      end else if (rnd_wait) begin
        avm_waitrequest = ($urandom_range(0, 2) == 0);
      end
    end else if (avm_read && rnd_wait) begin
      avm_waitrequest = ($urandom_range(0, 2) == 0);
    end
    avm_readdata[6] = !tx_hold && (poll_fail_left == 0);

    rd_acc = avm_read && !avm_waitrequest;
    wr_acc = avm_write && !avm_waitrequest;
    if (avm_write && avm_waitrequest) n_wr_stalls++;
    if (rd_acc) begin
      chk("rd_addr", 32'(avm_address), 32'd8);
      n_reads++;
      reads_since_write++;
      if (!avm_readdata[6] && poll_fail_left > 0) poll_fail_left--;
    end
    if (wr_acc) begin
      chk("wr_addr", 32'(avm_address), 32'd4);
      chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("wr_data", avm_writedata, {24'b0, exp_q.pop_front()});
      wr_log.push_back(avm_writedata[7:0]);
      polls_q.push_back(reads_since_write);
      reads_since_write = 0;
      wr_wait_cnt = 0;
      n_writes++;
    end
    push_acc = v && (model_count < 16);
    if (v && !push_acc) ovf_exp = 1;
    prev_rd_stall = avm_read && avm_waitrequest;
    prev_wr_stall = avm_write && avm_waitrequest;
    prev_addr     = avm_address;
    prev_wdata    = avm_writedata;

    @(posedge avm_clk);
    if (push_acc) begin
      exp_q.push_back(ref_ascii(int'(l)));
      n_pushed++;
    end
    model_count += int'(push_acc) - int'(wr_acc);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(o_busy), 32'd0);
  endtask

  // Asserts reset between edges and checks outputs respond asynchronously.
  task automatic apply_reset();
    #2;
    avm_rst_n      = 1'b0;
    i_letter_valid = 1'b0;
    #1;
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    exp_q.delete();
    model_count = 0; ovf_exp = 0; reads_since_write = 0;
    poll_fail_left = 0; wr_wait_cnt = 0;
    prev_rd_stall = 0; prev_wr_stall = 0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge avm_clk);
    avm_rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(o_letter_ready), 32'd1);
  endtask

  initial begin
    int w0, p0, r0, s0, k;
    byte unsigned t2_exp[5];
    logic [7:0] t2_codes[5];

    apply_reset();

    // 1: single code, latency and framing
    cycle(1'b1, 8'd0);
    chk("t1_read_n", 32'(avm_read), 32'd0);
    chk("t1_busy_n", 32'(o_busy), 32'd1);
    cycle(1'b0, 8'd0);
    chk("t1_read_n1", 32'(avm_read), 32'd1);
    chk("t1_addr_n1", 32'(avm_address), 32'd8);
    cycle(1'b0, 8'd0);
    chk("t1_write_n2", 32'(avm_write), 32'd1);
    chk("t1_read_n2", 32'(avm_read), 32'd0);
    chk("t1_addr_n2", 32'(avm_address), 32'd4);
    chk("t1_wdata_n2", avm_writedata, 32'h61);
    cycle(1'b0, 8'd0);
    chk("t1_write_n3", 32'(avm_write), 32'd0);
    chk("t1_busy_n3", 32'(o_busy), 32'd0);

    // 2: back-to-back codes incl. upper bits ignored and an unassigned code
    t2_codes = '{8'd26, 8'd52, 8'd63, 8'd99, 8'd56};
    t2_exp   = '{8'h41, 8'h20, 8'h0A, 8'h4A, 8'h3F};
    w0 = wr_log.size();
    for (int i = 0; i < 5; i++) cycle(1'b1, t2_codes[i]);
    drain();
    chk("t2_nwrites", 32'(wr_log.size() - w0), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (w0 + i < wr_log.size()) begin
        chk("t2_byte", 32'(wr_log[w0+i]), 32'(t2_exp[i]));
        chk("t2_polls", 32'(polls_q[w0+i]), 32'd1);
      end
    end

    // 3: TX not ready for 5 polls, write stalled 3 cycles
    w0 = n_writes; s0 = n_wr_stalls;
    poll_fail_left = 5; wr_stall = 3;
    cycle(1'b1, 8'd30);
    drain();
    chk("t3_nwrites", 32'(n_writes - w0), 32'd1);
    chk("t3_polls", 32'(polls_q[polls_q.size()-1]), 32'd6);
    chk("t3_stalls", 32'(n_wr_stalls - s0), 32'd3);
    chk("t3_byte", 32'(wr_log[wr_log.size()-1]), 32'h45);
    wr_stall = 0;

    // 4: overfill while TX held off
    w0 = n_writes;
    tx_hold = 1;
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i + 1));
    chk("t4_ready", 32'(o_letter_ready), 32'd0);
    chk("t4_overflow", 32'(o_overflow), 32'd1);
    tx_hold = 0;
    drain();
    chk("t4_nwrites", 32'(n_writes - w0), 32'd16);

    // 5: push coinciding with a pop on a full FIFO is dropped
    apply_reset();
    w0 = n_writes;
    tx_hold = 1;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(40 + i));
    tx_hold = 0;
    k = 0;
    while (!avm_write && k < 20) begin
      cycle(1'b0, 8'd0);
      k++;
    end
    chk("t5_write_seen", 32'(avm_write), 32'd1);
    tx_hold = 1;
    cycle(1'b1, 8'd5);
    chk("t5_overflow", 32'(o_overflow), 32'd1);
    chk("t5_ready_after_pop", 32'(o_letter_ready), 32'd1);
    cycle(1'b1, 8'd6);
    chk("t5_ready_refull", 32'(o_letter_ready), 32'd0);
    tx_hold = 0;
    drain();
    chk("t5_nwrites", 32'(n_writes - w0), 32'd17);

    // 6: reset during a stalled write
    wr_stall = 10;
    cycle(1'b1, 8'd2);
    k = 0;
    while (!avm_write && k < 20) begin
      cycle(1'b0, 8'd0);
      k++;
    end
    chk("t6_write_seen", 32'(avm_write), 32'd1);
    cycle(1'b0, 8'd0);
    chk("t6_stalled", 32'(avm_waitrequest), 32'd1);
    w0 = n_writes;
    apply_reset();
    wr_stall = 0;
    repeat (20) cycle(1'b0, 8'd0);
    chk("t6_no_write", 32'(n_writes - w0), 32'd0);
    chk("t6_idle_busy", 32'(o_busy), 32'd0);
    cycle(1'b1, 8'd51);
    drain();
    chk("t6_recover_n", 32'(n_writes - w0), 32'd1);
    chk("t6_recover_byte", 32'(wr_log[wr_log.size()-1]), 32'h5A);

    // Randomized traffic with random stalls and TX-not-ready polls
    rnd_wait = 1;
    w0 = n_writes; p0 = n_pushed; r0 = n_reads;
    for (int i = 0; i < 1500; i++) begin
      if (poll_fail_left == 0 && $urandom_range(0, 15) == 0) poll_fail_left = $urandom_range(1, 3);
      cycle($urandom_range(0, 2) == 0, 8'($urandom));
    end
    drain();
    chk("rnd_count", 32'(n_writes - w0), 32'(n_pushed - p0));
    chk("rnd_reads_min", 32'(n_reads - r0 >= n_writes - w0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
